sm_wb_arbiter: RTL



---
 rtl/sm_wb_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sm_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the I2C master register port.
// Master 0 is the sensor manager, master 1 the host/CPU port. The slave is
// granted for a whole CYC tenure; contention is resolved round-robin.
// Optional stuck-transfer watchdog enabled by defining ARB_TIMEOUT_EN.
module sm_wb_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              CLK_IN,
  input  logic              RESET_IN,
  // master 0 (sensor manager)
  input  logic              M0_CYC_I,
  input  logic              M0_STB_I,
  input  logic              M0_WE_I,
  input  logic [ADDR_W-1:0] M0_ADR_I,
  input  logic [DATA_W-1:0] M0_DAT_I,
  output logic [DATA_W-1:0] M0_DAT_O,
  output logic              M0_ACK_O,
  // master 1 (host)
  input  logic              M1_CYC_I,
  input  logic              M1_STB_I,
  input  logic              M1_WE_I,
  input  logic [ADDR_W-1:0] M1_ADR_I,
  input  logic [DATA_W-1:0] M1_DAT_I,
  output logic [DATA_W-1:0] M1_DAT_O,
  output logic              M1_ACK_O,
  // slave
  output logic              S_CYC_O,
  output logic              S_STB_O,
  output logic              S_WE_O,
  output logic [ADDR_W-1:0] S_ADR_O,
  output logic [DATA_W-1:0] S_DAT_O,
  input  logic [DATA_W-1:0] S_DAT_I,
  input  logic              S_ACK_I,
  // status
  output logic [1:0]        GNT_O,
  output logic              TIMEOUT_O
);

  typedef enum logic [1:0] {
    ArbIdle    = 2'b00,
    ArbGnt0    = 2'b01,
    ArbGnt1    = 2'b10,
    ArbRelease = 2'b11
  } arb_state_e;

  // Last watchdog count before it fires
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  arb_state_e r_state, w_state_d;
  arb_state_e w_arb;
  logic       r_last_gnt, w_last_gnt_d;  // 0 = M0 last granted, 1 = M1
  logic       w_gnt0, w_gnt1, w_in_gnt;
  logic       w_stb_sel;
  logic       w_wd_fire;

  assign w_gnt0    = (r_state == ArbGnt0);
  assign w_gnt1    = (r_state == ArbGnt1);
  assign w_in_gnt  = w_gnt0 | w_gnt1;
  assign w_stb_sel = (w_gnt0 & M0_STB_I) | (w_gnt1 & M1_STB_I);
  assign GNT_O     = {w_gnt1, w_gnt0};

  // Arbitration decision and next-state selection
  always_comb begin
    w_arb        = ArbIdle;
    w_state_d    = r_state;
    w_last_gnt_d = r_last_gnt;
    unique case ({M1_CYC_I, M0_CYC_I})
      2'b01:   w_arb = ArbGnt0;
      2'b10:   w_arb = ArbGnt1;
      2'b11:   w_arb = r_last_gnt ? ArbGnt0 : ArbGnt1;
      default: w_arb = ArbIdle;
    endcase
    case (r_state)
      ArbIdle, ArbRelease: begin
        w_state_d = w_arb;
        if (w_arb == ArbGnt0) w_last_gnt_d = 1'b0;
        if (w_arb == ArbGnt1) w_last_gnt_d = 1'b1;
      end
      ArbGnt0: if (!M0_CYC_I) w_state_d = ArbRelease;
      ArbGnt1: if (!M1_CYC_I) w_state_d = ArbRelease;
      default: w_state_d = ArbIdle;
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      r_state    <= ArbIdle;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_last_gnt <= w_last_gnt_d;
    end
  end

  // Bus muxing; acks are suppressed during reset so a dying transfer never completes
  always_comb begin
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    M0_ACK_O = 1'b0;
    M0_DAT_O = '0;
    M1_ACK_O = 1'b0;
    M1_DAT_O = '0;
    case (r_state)
      ArbGnt0: begin
        S_CYC_O  = M0_CYC_I;
        S_STB_O  = M0_STB_I;
        S_WE_O   = M0_WE_I;
        S_ADR_O  = M0_ADR_I;
        S_DAT_O  = M0_DAT_I;
        M0_ACK_O = S_ACK_I | w_wd_fire;
        M0_DAT_O = w_wd_fire ? '1 : S_DAT_I;
      end
      ArbGnt1: begin
        S_CYC_O  = M1_CYC_I;
        S_STB_O  = M1_STB_I;
        S_WE_O   = M1_WE_I;
        S_ADR_O  = M1_ADR_I;
        S_DAT_O  = M1_DAT_I;
        M1_ACK_O = S_ACK_I | w_wd_fire;
        M1_DAT_O = w_wd_fire ? '1 : S_DAT_I;
      end
      default: ;
    endcase
    M0_ACK_O = M0_ACK_O & ~RESET_IN;
    M1_ACK_O = M1_ACK_O & ~RESET_IN;
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_wd_cnt, w_wd_cnt_d;
  logic       r_timeout;

  // Watchdog: counts unacknowledged strobe cycles within a tenure
  always_comb begin
    w_wd_fire  = w_in_gnt & w_stb_sel & ~S_ACK_I & (r_wd_cnt == TimeoutLast);
    w_wd_cnt_d = r_wd_cnt;
    if (!w_in_gnt || S_ACK_I || w_wd_fire) begin
      w_wd_cnt_d = 8'd0;
    end else if (w_stb_sel) begin
      w_wd_cnt_d = r_wd_cnt + 8'd1;
    end
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      r_wd_cnt  <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_cnt_d;
      r_timeout <= r_timeout | w_wd_fire;
    end
  end

  assign TIMEOUT_O = r_timeout;
`else
  logic w_unused_timeout;

  assign w_wd_fire        = 1'b0;
  assign TIMEOUT_O        = 1'b0;
  assign w_unused_timeout = ^{TimeoutLast, w_stb_sel, w_in_gnt};
`endif

endmodule
